key_tone_player: RTL and testbench



---
 rtl/key_tone_player.sv | 168 ++++++++++++++++
 tb/tb_key_tone_player.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_tone_player.sv
// key_tone_player: turns each newly pressed keypad key into a fixed-length square-wave
// note on the beeper, followed by a silent gap.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   en        playback enable; low mutes and forces IDLE
//   key_code  latched key code from the keypad scanner (slow clock domain)
//   beep      square-wave drive to the beeper (registered)
//   playing   high while a note is sounding (registered)
//   note_idx  index of the current or last played note (registered)
//
// The 16 keys map to a major scale from C4 (index 0) to D6 (index 15). A key code is
// valid when bits [7:6] are 00 and bits [5:4] are 01 or 10; bits [3:0] select the note.
module key_tone_player #(
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned NOTE_CYCLES = 25000000,
    parameter int unsigned GAP_CYCLES  = 2500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] key_code,
    output logic       beep,
    output logic       playing,
    output logic [3:0] note_idx
);

    localparam int unsigned FREQ_HZ [16] = '{
        262, 294, 330, 349, 392, 440, 494, 523,
        587, 659, 698, 784, 880, 988, 1047, 1175
    };

    // The lowest note has the longest half-period, so it sizes the phase counter.
    localparam int unsigned HALF_MAX = CLK_HZ / (2 * 262);
    localparam int unsigned PH_W     = (HALF_MAX > 2) ? $clog2(HALF_MAX) : 1;
    localparam int unsigned DUR_MAX  = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
    localparam int unsigned DUR_W    = (DUR_MAX > 2) ? $clog2(DUR_MAX) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StPlay,
        StGap
    } state_e;

    // Half-period minus one per note; constant after elaboration.
    logic [PH_W-1:0] half_m1 [16];
    for (genvar i = 0; i < 16; i++) begin : g_half
        assign half_m1[i] = PH_W'(CLK_HZ / (2 * FREQ_HZ[i]) - 1);
    end

    logic [7:0]       s1_q, s2_q, s3_q;
    logic [7:0]       last_q, last_d;
    state_e           state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic             beep_q, beep_d;
    logic             playing_q, playing_d;
    logic [3:0]       note_q, note_d;

    logic s3_valid;
    logic accept;

    // A code must be seen identical in two consecutive stages before it is accepted,
    // which filters single-cycle glitches from the slow scanner domain.
    always_comb begin
        s3_valid = (s3_q[7:6] == 2'b00) && ((s3_q[5:4] == 2'b01) || (s3_q[5:4] == 2'b10));
        accept   = (s2_q == s3_q) && s3_valid && (s3_q != last_q);
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        dur_d     = dur_q;
        beep_d    = beep_q;
        playing_d = playing_q;
        note_d    = note_q;
        // Accepted codes are remembered even while muted so that re-enabling
        // does not replay the last key.
        last_d    = accept ? s3_q : last_q;

        if (!en) begin
            state_d   = StIdle;
            phase_d   = '0;
            dur_d     = '0;
            beep_d    = 1'b0;
            playing_d = 1'b0;
        end else if (accept) begin
            // New note wins over any end-of-note or end-of-gap transition.
            state_d   = StPlay;
            note_d    = s3_q[3:0];
            phase_d   = '0;
            dur_d     = '0;
            beep_d    = 1'b0;
            playing_d = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    beep_d    = 1'b0;
                    playing_d = 1'b0;
                end
                StPlay: begin
                    if (dur_q == DUR_W'(NOTE_CYCLES - 1)) begin
                        state_d   = StGap;
                        dur_d     = '0;
                        phase_d   = '0;
                        beep_d    = 1'b0;
                        playing_d = 1'b0;
                    end else begin
                        dur_d = dur_q + DUR_W'(1);
                        if (phase_q == half_m1[note_q]) begin
                            phase_d = '0;
                            beep_d  = ~beep_q;
                        end else begin
                            phase_d = phase_q + PH_W'(1);
                        end
                    end
                end
                StGap: begin
                    beep_d    = 1'b0;
                    playing_d = 1'b0;
                    if (dur_q == DUR_W'(GAP_CYCLES - 1)) begin
                        state_d = StIdle;
                        dur_d   = '0;
                    end else begin
                        dur_d = dur_q + DUR_W'(1);
                    end
                end
                default: begin
                    state_d   = StIdle;
                    beep_d    = 1'b0;
                    playing_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= 8'h00;
            s2_q      <= 8'h00;
            s3_q      <= 8'h00;
            last_q    <= 8'h00;
            state_q   <= StIdle;
            phase_q   <= '0;
            dur_q     <= '0;
            beep_q    <= 1'b0;
            playing_q <= 1'b0;
            note_q    <= 4'd0;
        end else begin
            s1_q      <= key_code;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            last_q    <= last_d;
            state_q   <= state_d;
            phase_q   <= phase_d;
            dur_q     <= dur_d;
            beep_q    <= beep_d;
            playing_q <= playing_d;
            note_q    <= note_d;
        end
    end

    assign beep     = beep_q;
    assign playing  = playing_q;
    assign note_idx = note_q;

endmodule

// File: tb/tb_key_tone_player.sv
// Testbench for key_tone_player: directed scenarios with literal timing expectations plus
// randomized key traffic, all compared every cycle against a time-based behavioural model.
module tb_key_tone_player;

    localparam int unsigned CLK_HZ      = 1000000;
    localparam int unsigned NOTE_CYCLES = 20000;
    localparam int unsigned GAP_CYCLES  = 2000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic [7:0] key_code = 8'h00;
    logic       beep;
    logic       playing;
    logic [3:0] note_idx;

    key_tone_player #(
        .CLK_HZ      (CLK_HZ),
        .NOTE_CYCLES (NOTE_CYCLES),
        .GAP_CYCLES  (GAP_CYCLES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .key_code (key_code),
        .beep     (beep),
        .playing  (playing),
        .note_idx (note_idx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_on   = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- reference model
    // Tracks the sampled key history, the last accepted code and the clock count at
    // which the current note began; outputs are derived from elapsed time.
    int unsigned freq_tab [16] = '{262, 294, 330, 349, 392, 440, 494, 523,
                                   587, 659, 698, 784, 880, 988, 1047, 1175};
    longint     cyc = 0;
    longint     start_cyc = 0;
    bit         active = 1'b0;
    logic [7:0] last_acc = 8'h00;
    logic [3:0] m_note = 4'd0;
    logic [7:0] samp [$] = '{8'h00, 8'h00, 8'h00};  // samp[0] = most recent sample

    function automatic bit is_valid(input logic [7:0] c);
        return (c[7:6] == 2'b00) && ((c[5:4] == 2'b01) || (c[5:4] == 2'b10));
    endfunction

    initial begin
        bit acc;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                cyc = 0;
                start_cyc = 0;
                active = 1'b0;
                last_acc = 8'h00;
                m_note = 4'd0;
                samp = '{8'h00, 8'h00, 8'h00};
            end else begin
                cyc++;
                acc = (samp[1] == samp[2]) && is_valid(samp[2]) && (samp[2] != last_acc);
                if (acc) last_acc = samp[2];
                if (!en) begin
                    active = 1'b0;
                end else if (acc) begin
                    active = 1'b1;
                    start_cyc = cyc;
                    m_note = samp[2][3:0];
                end
                samp.push_front(key_code);
                void'(samp.pop_back());
            end
        end
    end

    function automatic void model_out(output logic b, output logic p);
        longint el;
        longint h;
        b = 1'b0;
        p = 1'b0;
        if (active) begin
            el = cyc - start_cyc;
            h  = longint'(CLK_HZ / (2 * freq_tab[m_note]));
            if (el < longint'(NOTE_CYCLES)) begin
                p = 1'b1;
                b = ((el / h) % 2) == 1;
            end
        end
    endfunction

    always @(negedge clk) begin
        logic mb, mp;
        if (cmp_on) begin
            model_out(mb, mp);
            check("cmp_beep", longint'(beep), longint'(mb));
            check("cmp_playing", longint'(playing), longint'(mp));
            check("cmp_note_idx", longint'(note_idx), longint'(m_note));
        end
    end

    // ---------------------------------------------------------------- helpers
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic logic sig(input int s);
        return (s == 0) ? beep : playing;
    endfunction

    // Cycles until beep (s=0) or playing (s=1) reaches v; returns limit on timeout.
    task automatic wait_for(input int s, input logic v, input int limit, output int n);
        n = 0;
        while (sig(s) !== v && n < limit) begin
            step(1);
            n++;
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------- stimulus
    initial begin
        int n;
        logic [7:0] prev;
        prev = 8'h10;

        repeat (3) @(posedge clk);
        #2;
        check("reset_beep", longint'(beep), 0);
        check("reset_playing", longint'(playing), 0);
        check("reset_note_idx", longint'(note_idx), 0);
        rst_n = 1'b1;
        cmp_on = 1'b1;
        step(2);

        // Note 0: latency, half-period, duration, gap, held key plays once.
        key_code = 8'h10;
        step(3);
        check("t1_playing_before_4th_edge", longint'(playing), 0);
        step(1);
        check("t1_playing_on_4th_edge", longint'(playing), 1);
        check("t1_note_idx", longint'(note_idx), 0);
        check("t1_beep_at_entry", longint'(beep), 0);
        wait_for(0, 1'b1, 5000, n);
        check("t1_first_rise", n, 1908);
        wait_for(0, 1'b0, 5000, n);
        check("t1_first_fall", n, 1908);
        wait_for(1, 1'b0, 25000, n);
        check("t1_note_end", n, 16184);
        step(GAP_CYCLES + 300);
        check("t1_held_no_replay", longint'(playing), 0);
        check("t1_idle_beep", longint'(beep), 0);

        // Invalid codes are ignored; 0x00 must not clear the last accepted code.
        key_code = 8'h35; step(20);
        check("t4_ignore_35", longint'(playing), 0);
        key_code = 8'h4F; step(20);
        check("t4_ignore_4F", longint'(playing), 0);
        key_code = 8'h00; step(20);
        check("t4_ignore_00", longint'(playing), 0);
        key_code = 8'h10; step(20);
        check("t4_same_after_00", longint'(playing), 0);

        // Highest note, then retrigger to index 8.
        key_code = 8'h2F; step(4);
        check("t2_note_15", longint'(note_idx), 15);
        check("t2_playing", longint'(playing), 1);
        wait_for(0, 1'b1, 3000, n);
        check("t2_half_15_rise", n, 425);
        wait_for(0, 1'b0, 3000, n);
        check("t2_half_15_fall", n, 425);
        key_code = 8'h28; step(4);
        check("t2_note_8", longint'(note_idx), 8);
        check("t2_beep_restart", longint'(beep), 0);
        wait_for(0, 1'b1, 3000, n);
        check("t2_half_8_rise", n, 851);

        // One-cycle glitch between stable codes must not restart the note.
        key_code = 8'h12; step(4);
        check("t4_note_2", longint'(note_idx), 2);
        step(20);
        key_code = 8'h2A; step(1);
        key_code = 8'h12; step(30);
        check("t4_glitch_note_idx", longint'(note_idx), 2);
        check("t4_glitch_playing", longint'(playing), 1);
        wait_for(0, 1'b1, 3000, n);
        check("t4_glitch_no_restart", n, 1464);

        // Retrigger 5000 cycles into a note restarts phase and duration.
        key_code = 8'h15; step(4);
        check("t3_note_5", longint'(note_idx), 5);
        step(5000);
        key_code = 8'h2D; step(3);
        check("t3_old_note_held", longint'(note_idx), 5);
        step(1);
        check("t3_note_13", longint'(note_idx), 13);
        check("t3_beep_restart", longint'(beep), 0);
        check("t3_playing", longint'(playing), 1);
        wait_for(0, 1'b1, 3000, n);
        check("t3_half_13_rise", n, 506);
        wait_for(1, 1'b0, 25000, n);
        check("t3_full_note_after_retrigger", n, 19494);

        // Asynchronous reset mid-note.
        key_code = 8'h17; step(4);
        check("t5_note_7", longint'(note_idx), 7);
        step(3000);
        check("t5_beep_high_before_reset", longint'(beep), 1);
        rst_n = 1'b0;
        #1;
        check("t5_async_beep", longint'(beep), 0);
        check("t5_async_playing", longint'(playing), 0);
        check("t5_async_note_idx", longint'(note_idx), 0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        key_code = 8'h13;
        step(3);
        check("t5_post_reset_wait", longint'(playing), 0);
        step(1);
        check("t5_post_reset_play", longint'(playing), 1);
        check("t5_post_reset_note", longint'(note_idx), 3);

        // Enable: mute mid-note, accept while muted, no replay on re-enable.
        step(1000);
        en = 1'b0; step(1);
        check("t6_mute_playing", longint'(playing), 0);
        check("t6_mute_beep", longint'(beep), 0);
        key_code = 8'h11; step(20);
        check("t6_no_note_while_muted", longint'(playing), 0);
        en = 1'b1; step(50);
        check("t6_no_replay_on_enable", longint'(playing), 0);
        check("t6_note_idx_held", longint'(note_idx), 3);
        key_code = 8'h16; step(4);
        check("t6_new_code_plays", longint'(playing), 1);
        check("t6_new_note_idx", longint'(note_idx), 6);

        // Randomized traffic: valid/invalid codes, glitches, repeats, enable toggles.
        for (int i = 0; i < 80; i++) begin
            int r;
            int hold;
            r = int'($urandom_range(0, 9));
            if (r < 6) begin
                key_code = {2'b00, ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10,
                            4'($urandom_range(0, 15))};
            end else if (r < 8) begin
                key_code = 8'($urandom);
            end else begin
                key_code = prev;
            end
            prev = key_code;
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) hold = 900;
            else if ($urandom_range(0, 4) == 0) hold = 1;
            else hold = int'($urandom_range(2, 60));
            step(hold);
        end
        en = 1'b1;
        step(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
